// File: rtl/fake_imem_nport_if.sv
// Fetch-side bus for the fake instruction memory: preload port, flush,
// and per-port request/response handshakes packed as flat vectors.
interface fake_imem_nport_if #(
   parameter int P_NUM_PORTS = 2,
   parameter int P_DEPTH     = 64
);
   localparam int AW = $clog2(P_DEPTH);

   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [31:0]              wr_data;
   logic                     flush;
   logic [P_NUM_PORTS-1:0]   req_val;
   logic [P_NUM_PORTS-1:0]   req_rdy;
   logic [32*P_NUM_PORTS-1:0] req_addr;
   logic [P_NUM_PORTS-1:0]   resp_val;
   logic [P_NUM_PORTS-1:0]   resp_rdy;
   logic [32*P_NUM_PORTS-1:0] resp_instr;
   logic [P_NUM_PORTS-1:0]   resp_err;

   // Core fetch stage / bench side
   modport master (
      output wr_en, wr_addr, wr_data, flush, req_val, req_addr, resp_rdy,
      input  req_rdy, resp_val, resp_instr, resp_err
   );

   // Memory model side
   modport slave (
      input  wr_en, wr_addr, wr_data, flush, req_val, req_addr, resp_rdy,
      output req_rdy, resp_val, resp_instr, resp_err
   );
endinterface

// File: rtl/fake_imem_nport.sv
// Multi-port instruction memory model: one shared word array, per-port
// fixed-latency response pipeline with backpressure and global flush.
module fake_imem_nport #(
   parameter int          P_NUM_PORTS = 2,
   parameter int          P_DEPTH     = 64,
   parameter logic [31:0] P_BASE      = 32'h200,
   parameter int          P_LAT       = 1,
   parameter logic [31:0] P_NOP       = 32'h00000013
) (
   input logic               clk,
   input logic               reset,
   fake_imem_nport_if.slave  bus
);
   localparam int AW = $clog2(P_DEPTH);

   logic [31:0] mem [P_DEPTH];

   logic [P_NUM_PORTS-1:0]    req_rdy_w;
   logic [P_NUM_PORTS-1:0]    resp_val_w;
   logic [P_NUM_PORTS-1:0]    resp_err_w;
   logic [32*P_NUM_PORTS-1:0] resp_instr_w;

   // Preload write; the array is deliberately outside reset so a program
   // survives a core reset. Reads in the same cycle see the old word.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   generate
      for (genvar gi = 0; gi < P_NUM_PORTS; gi++) begin : g_port
         logic [31:0]      addr;
         logic [31:0]      word_idx;
         logic             addr_err;
         logic [31:0]      rd_word;
         logic             stall;
         logic             accept;
         logic [P_LAT-1:0] val_q, val_d;
         logic [P_LAT-1:0] err_q, err_d;
         logic [31:0]      instr_q [P_LAT];
         logic [31:0]      instr_d [P_LAT];

         assign addr   = bus.req_addr[32*gi +: 32];
         // Whole pipe freezes while the head is valid and not taken.
         assign stall  = val_q[P_LAT-1] & ~bus.resp_rdy[gi];
         assign req_rdy_w[gi] = ~bus.flush & ~stall;
         assign accept = bus.req_val[gi] & req_rdy_w[gi];

         // Address decode and array lookup for the request presented this cycle
         always_comb begin
            word_idx = (addr - P_BASE) >> 2;
            addr_err = (addr[1:0] != 2'b00) || (addr < P_BASE) ||
                       (word_idx >= 32'(P_DEPTH));
            rd_word  = mem[word_idx[AW-1:0]];
         end

         // Next pipeline contents: hold on stall, else shift toward the head
         always_comb begin
            val_d   = val_q;
            err_d   = err_q;
            instr_d = instr_q;
            if (!stall) begin
               for (int k = 1; k < P_LAT; k++) begin
                  val_d[k]   = val_q[k-1];
                  err_d[k]   = err_q[k-1];
                  instr_d[k] = instr_q[k-1];
               end
               val_d[0]   = accept;
               err_d[0]   = addr_err;
               instr_d[0] = addr_err ? P_NOP : rd_word;
            end
            if (bus.flush) begin
               val_d = '0;
            end
         end

         // Pipeline registers; reset drops everything in flight at once
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               val_q <= '0;
               err_q <= '0;
               for (int k = 0; k < P_LAT; k++) begin
                  instr_q[k] <= '0;
               end
            end else begin
               val_q   <= val_d;
               err_q   <= err_d;
               instr_q <= instr_d;
            end
         end

         assign resp_val_w[gi]            = val_q[P_LAT-1];
         assign resp_err_w[gi]            = err_q[P_LAT-1];
         assign resp_instr_w[32*gi +: 32] = instr_q[P_LAT-1];
      end
   endgenerate

   assign bus.req_rdy    = req_rdy_w;
   assign bus.resp_val   = resp_val_w;
   assign bus.resp_err   = resp_err_w;
   assign bus.resp_instr = resp_instr_w;
endmodule

// File: tb/tb_fake_imem_nport.sv
// Directed bench for fake_imem_nport: three instances at latencies 1, 2, 3.
module tb_fake_imem_nport;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fake_imem_nport_if #(.P_NUM_PORTS(2), .P_DEPTH(64)) b1 ();
   fake_imem_nport_if #(.P_NUM_PORTS(2), .P_DEPTH(64)) b2 ();
   fake_imem_nport_if #(.P_NUM_PORTS(2), .P_DEPTH(64)) b3 ();

   fake_imem_nport #(.P_NUM_PORTS(2), .P_DEPTH(64), .P_BASE(32'h200), .P_LAT(1), .P_NOP(NOP))
      dut1 (.clk(clk), .reset(rst_n), .bus(b1));
   fake_imem_nport #(.P_NUM_PORTS(2), .P_DEPTH(64), .P_BASE(32'h200), .P_LAT(2), .P_NOP(NOP))
      dut2 (.clk(clk), .reset(rst_n), .bus(b2));
   fake_imem_nport #(.P_NUM_PORTS(2), .P_DEPTH(64), .P_BASE(32'h200), .P_LAT(3), .P_NOP(NOP))
      dut3 (.clk(clk), .reset(rst_n), .bus(b3));

   function automatic logic [31:0] pre(int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   task automatic idle_all();
      b1.wr_en = 0; b1.wr_addr = '0; b1.wr_data = '0; b1.flush = 0;
      b1.req_val = '0; b1.req_addr = '0; b1.resp_rdy = 2'b11;
      b2.wr_en = 0; b2.wr_addr = '0; b2.wr_data = '0; b2.flush = 0;
      b2.req_val = '0; b2.req_addr = '0; b2.resp_rdy = 2'b11;
      b3.wr_en = 0; b3.wr_addr = '0; b3.wr_data = '0; b3.flush = 0;
      b3.req_val = '0; b3.req_addr = '0; b3.resp_rdy = 2'b11;
   endtask

   task automatic test_reset();
      idle_all();
      @(negedge clk);
      n_checks++;
      if ({b1.resp_val, b1.resp_err, b1.resp_instr} !== 68'd0) begin
         n_fail++; $display("FAIL reset_b1: got val=%b err=%b instr=%h want all 0", b1.resp_val, b1.resp_err, b1.resp_instr);
      end
      n_checks++;
      if ({b2.resp_val, b2.resp_err, b2.resp_instr} !== 68'd0) begin
         n_fail++; $display("FAIL reset_b2: got val=%b err=%b instr=%h want all 0", b2.resp_val, b2.resp_err, b2.resp_instr);
      end
      n_checks++;
      if ({b3.resp_val, b3.resp_err, b3.resp_instr} !== 68'd0) begin
         n_fail++; $display("FAIL reset_b3: got val=%b err=%b instr=%h want all 0", b3.resp_val, b3.resp_err, b3.resp_instr);
      end
      n_checks++;
      if ({b1.req_rdy, b2.req_rdy, b3.req_rdy} !== 6'b111111) begin
         n_fail++; $display("FAIL reset_rdy: got %b want 111111", {b1.req_rdy, b2.req_rdy, b3.req_rdy});
      end
      rst_n = 1'b1;
      $display("reset: done");
   endtask

   task automatic preload();
      for (int i = 0; i <= 20; i++) begin
         b1.wr_en = 1; b1.wr_addr = 6'(i); b1.wr_data = pre(i);
         b2.wr_en = 1; b2.wr_addr = 6'(i); b2.wr_data = pre(i);
         b3.wr_en = 1; b3.wr_addr = 6'(i); b3.wr_data = pre(i);
         @(negedge clk);
      end
      b1.wr_en = 0; b2.wr_en = 0; b3.wr_en = 0;
      $display("preload: words 0..20 written");
   endtask

   task automatic test_back_to_back();
      b1.req_val = 2'b01; b1.req_addr[31:0] = 32'h200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({b1.resp_val[0], b1.resp_err[0], b1.resp_instr[31:0], b1.req_rdy[0]} !== {1'b1, 1'b0, pre(i), 1'b1}) begin
            n_fail++; $display("FAIL b2b_word%0d: got val=%b err=%b instr=%h rdy=%b want 1 0 %h 1", i,
                               b1.resp_val[0], b1.resp_err[0], b1.resp_instr[31:0], b1.req_rdy[0], pre(i));
         end
         $display("b2b: word %0d instr=%h", i, b1.resp_instr[31:0]);
         if (i < 2) b1.req_addr[31:0] = 32'h200 + 32'(4 * (i + 1));
         else       b1.req_val = 2'b00;
      end
      @(negedge clk);
      n_checks++;
      if (b1.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL b2b_drain: got resp_val=%b want 00", b1.resp_val);
      end
   endtask

   task automatic test_same_word_and_errors();
      b1.req_val = 2'b11; b1.req_addr = {32'h240, 32'h240};
      @(negedge clk);
      n_checks++;
      if ({b1.resp_val, b1.resp_err, b1.resp_instr} !== {2'b11, 2'b00, pre(16), pre(16)}) begin
         n_fail++; $display("FAIL same_word: got val=%b err=%b instr=%h want 11 00 %h%h", b1.resp_val, b1.resp_err, b1.resp_instr, pre(16), pre(16));
      end
      $display("same_word: instr=%h", b1.resp_instr);
      b1.req_addr = {32'h202, 32'h1FC};
      @(negedge clk);
      n_checks++;
      if ({b1.resp_val, b1.resp_err, b1.resp_instr} !== {2'b11, 2'b11, NOP, NOP}) begin
         n_fail++; $display("FAIL err_below_misalign: got val=%b err=%b instr=%h want 11 11 nop", b1.resp_val, b1.resp_err, b1.resp_instr);
      end
      $display("err_below_misalign: err=%b", b1.resp_err);
      b1.req_addr = {32'h300, 32'h300};
      @(negedge clk);
      n_checks++;
      if ({b1.resp_val, b1.resp_err, b1.resp_instr} !== {2'b11, 2'b11, NOP, NOP}) begin
         n_fail++; $display("FAIL err_above: got val=%b err=%b instr=%h want 11 11 nop", b1.resp_val, b1.resp_err, b1.resp_instr);
      end
      $display("err_above: err=%b", b1.resp_err);
      b1.req_val = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      b3.resp_rdy = 2'b01; b3.req_val = 2'b11;
      b3.req_addr = {32'h200, 32'h210};
      @(negedge clk);   // N1
      n_checks++;
      if (b3.req_rdy !== 2'b11) begin
         n_fail++; $display("FAIL bp_fill1_rdy: got %b want 11", b3.req_rdy);
      end
      b3.req_addr[63:32] = 32'h204;
      @(negedge clk);   // N2
      n_checks++;
      if (b3.req_rdy !== 2'b11) begin
         n_fail++; $display("FAIL bp_fill2_rdy: got %b want 11", b3.req_rdy);
      end
      b3.req_addr[63:32] = 32'h208;
      for (int c = 3; c <= 4; c++) begin   // stalled head
         @(negedge clk);
         n_checks++;
         if ({b3.resp_val, b3.resp_err, b3.resp_instr, b3.req_rdy} !== {2'b11, 2'b00, pre(0), pre(4), 2'b01}) begin
            n_fail++; $display("FAIL bp_stall_n%0d: got val=%b err=%b instr=%h rdy=%b want 11 00 %h%h 01", c,
                               b3.resp_val, b3.resp_err, b3.resp_instr, b3.req_rdy, pre(0), pre(4));
         end
         $display("bp: stall cycle %0d p1 instr=%h", c, b3.resp_instr[63:32]);
         b3.req_val[1] = 1'b0;
      end
      b3.resp_rdy = 2'b11;
      for (int c = 5; c <= 6; c++) begin   // drain in order
         @(negedge clk);
         n_checks++;
         if ({b3.resp_val, b3.resp_err, b3.resp_instr} !== {2'b11, 2'b00, pre(c - 4), pre(4)}) begin
            n_fail++; $display("FAIL bp_drain_n%0d: got val=%b err=%b instr=%h want 11 00 %h%h", c,
                               b3.resp_val, b3.resp_err, b3.resp_instr, pre(c - 4), pre(4));
         end
         $display("bp: drain cycle %0d p1 instr=%h", c, b3.resp_instr[63:32]);
         b3.req_val[0] = 1'b0;
      end
      @(negedge clk);   // N7
      n_checks++;
      if ({b3.resp_val, b3.resp_instr[31:0]} !== {2'b01, pre(4)}) begin
         n_fail++; $display("FAIL bp_no_dup: got val=%b instr0=%h want 01 %h", b3.resp_val, b3.resp_instr[31:0], pre(4));
      end
      @(negedge clk);   // N8
      n_checks++;
      if (b3.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL bp_empty: got val=%b want 00", b3.resp_val);
      end
   endtask

   task automatic test_flush();
      b2.req_val = 2'b11; b2.req_addr = {32'h204, 32'h200};
      @(negedge clk);   // N1: both in stage 0
      n_checks++;
      if (b2.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL flush_pre: got val=%b want 00", b2.resp_val);
      end
      b2.flush = 1'b1; b2.req_val = 2'b10; b2.req_addr[63:32] = 32'h20C;
      #1;
      n_checks++;
      if (b2.req_rdy !== 2'b00) begin
         n_fail++; $display("FAIL flush_rdy: got %b want 00", b2.req_rdy);
      end
      @(negedge clk);   // N2
      b2.flush = 1'b0;
      n_checks++;
      if (b2.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL flush_lost1: got val=%b want 00", b2.resp_val);
      end
      b2.req_val = 2'b01; b2.req_addr[31:0] = 32'h208;
      @(negedge clk);   // N3
      n_checks++;
      if (b2.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL flush_lost2: got val=%b want 00", b2.resp_val);
      end
      b2.req_val = 2'b00;
      @(negedge clk);   // N4
      n_checks++;
      if ({b2.resp_val, b2.resp_err[0], b2.resp_instr[31:0]} !== {2'b01, 1'b0, pre(2)}) begin
         n_fail++; $display("FAIL flush_after: got val=%b err=%b instr=%h want 01 0 %h", b2.resp_val, b2.resp_err[0], b2.resp_instr[31:0], pre(2));
      end
      $display("flush: post-flush instr=%h", b2.resp_instr[31:0]);
      @(negedge clk);
      n_checks++;
      if (b2.resp_val !== 2'b00) begin
         n_fail++; $display("FAIL flush_drain: got val=%b want 00", b2.resp_val);
      end
   endtask

   task automatic test_write_collision();
      b1.wr_en = 1; b1.wr_addr = 6'd5; b1.wr_data = 32'hDEADBEEF;
      b1.req_val = 2'b01; b1.req_addr[31:0] = 32'h214;
      @(negedge clk);
      b1.wr_en = 0;
      n_checks++;
      if ({b1.resp_val[0], b1.resp_instr[31:0]} !== {1'b1, pre(5)}) begin
         n_fail++; $display("FAIL wr_old: got val=%b instr=%h want 1 %h", b1.resp_val[0], b1.resp_instr[31:0], pre(5));
      end
      $display("wr_collision: same-cycle read %h", b1.resp_instr[31:0]);
      @(negedge clk);
      n_checks++;
      if ({b1.resp_val[0], b1.resp_instr[31:0]} !== {1'b1, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL wr_new: got val=%b instr=%h want 1 deadbeef", b1.resp_val[0], b1.resp_instr[31:0]);
      end
      $display("wr_collision: reread %h", b1.resp_instr[31:0]);
      b1.req_val = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      b1.req_val = 2'b01; b1.req_addr[31:0] = 32'h200;
      b3.req_val = 2'b01; b3.req_addr[31:0] = 32'h204;
      @(negedge clk);
      b1.req_val = 2'b00; b3.req_val = 2'b00;
      n_checks++;
      if (b1.resp_val[0] !== 1'b1) begin
         n_fail++; $display("FAIL rst_inflight: got val=%b want 1", b1.resp_val[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({b1.resp_val, b1.resp_instr, b3.resp_val} !== 68'd0) begin
         n_fail++; $display("FAIL rst_async: got b1 val=%b instr=%h b3 val=%b want 0", b1.resp_val, b1.resp_instr, b3.resp_val);
      end
      @(negedge clk);
      rst_n = 1'b1;
      b1.req_val = 2'b01; b1.req_addr[31:0] = 32'h204;
      @(negedge clk);
      b1.req_val = 2'b00;
      n_checks++;
      if ({b1.resp_val[0], b1.resp_err[0], b1.resp_instr[31:0]} !== {1'b1, 1'b0, pre(1)}) begin
         n_fail++; $display("FAIL rst_refetch: got val=%b err=%b instr=%h want 1 0 %h", b1.resp_val[0], b1.resp_err[0], b1.resp_instr[31:0], pre(1));
      end
      $display("reset_midflight: refetch instr=%h", b1.resp_instr[31:0]);
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (b3.resp_val !== 2'b00) begin
            n_fail++; $display("FAIL rst_lost%0d: got b3 val=%b want 00", c, b3.resp_val);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      preload();
      test_back_to_back();
      test_same_word_and_errors();
      test_backpressure();
      test_flush();
      test_write_collision();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
